// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and state encoding for the 7-segment scan controller.
package seg7_scan_ctrl_pkg;

  localparam int unsigned DIG_W = 4;

  localparam logic [DIG_W-1:0] BCD_BLANK = 4'hF;

  // Slice to the digit count at the point of use.
  localparam logic [31:0] ANODE_OFF = '1;

  typedef enum logic [0:0] {
    ST_BLANK,
    ST_ON
  } state_t;

endpackage

// File: rtl/seg7_lzb_mask.sv
// Leading-zero suppress mask: digit i>0 is suppressed when it and every higher digit are zero.
module seg7_lzb_mask
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned NDIG = 4
) (
  input  logic [NDIG-1:0][DIG_W-1:0] digits,
  output logic [NDIG-1:0]            mask
);

  logic chain;

  always_comb begin
    chain = 1'b1;
    mask  = '0;
    // Walk from the most significant digit down; digit 0 is never suppressed.
    for (int i = NDIG - 1; i >= 1; i--) begin
      chain   = chain & (digits[i] == '0);
      mask[i] = chain;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display with
// anti-ghosting blanking, tear-free frame update and leading-zero blanking.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned NDIG      = 4,
  parameter int unsigned SLOT_CYC  = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIG_W*NDIG-1:0] digits_in,
  input  logic                  load,
  input  logic                  lzb_en,
  output logic [DIG_W-1:0]      bcd_out,
  output logic [NDIG-1:0]       an,
  output logic                  frame_tick
);

  localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned CW = $clog2(SLOT_CYC);

  localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);
  localparam state_t        ST_START   = (BLANK_CYC == 0) ? ST_ON : ST_BLANK;

  logic [NDIG-1:0][DIG_W-1:0] digits_arr;
  logic [NDIG-1:0][DIG_W-1:0] pend_q, pend_d;
  logic [NDIG-1:0][DIG_W-1:0] disp_q, disp_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  state_t                     state_q, state_d;
  logic                       run_q;
  logic [NDIG-1:0]            sup_mask;
  logic [NDIG-1:0]            an_d;
  logic [DIG_W-1:0]           bcd_d;
  logic                       tick_d;

  assign digits_arr = digits_in;

  seg7_lzb_mask #(
    .NDIG(NDIG)
  ) u_lzb_mask (
    .digits(disp_d),
    .mask  (sup_mask)
  );

  always_comb begin
    pend_d  = load ? digits_arr : pend_q;
    disp_d  = disp_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    // The first edge after reset only arms the scan so cycle 0 gets its frame_tick.
    if (run_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = ST_START;
        if (idx_q == IDX_LAST) begin
          idx_d  = '0;
          disp_d = pend_d;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (BLANK_CYC != 0 && state_q == ST_BLANK && cnt_q == BLANK_LAST) begin
          state_d = ST_ON;
        end
      end
    end

    // Outputs are computed from next state so they register on the same edge.
    an_d  = ANODE_OFF[NDIG-1:0];
    bcd_d = BCD_BLANK;
    if (state_d == ST_ON && !(lzb_en && sup_mask[idx_d])) begin
      an_d  = ~(NDIG'(1) << idx_d);
      bcd_d = disp_d[idx_d];
    end
    tick_d = (idx_d == '0) && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= '0;
      disp_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      state_q    <= ST_START;
      run_q      <= 1'b0;
      an         <= ANODE_OFF[NDIG-1:0];
      bcd_out    <= BCD_BLANK;
      frame_tick <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      disp_q     <= disp_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      run_q      <= 1'b1;
      an         <= an_d;
      bcd_out    <= bcd_d;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized self-checking bench for seg7_scan_ctrl against a cycle-index reference model.
module tb_seg7_scan_ctrl;

  localparam int unsigned NDIG  = 4;
  localparam int unsigned SLOT  = 8;
  localparam int unsigned BLANK = 2;
  localparam int unsigned FRAME = NDIG * SLOT;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] digits_in = '0;
  logic        load = 1'b0;
  logic        lzb_en = 1'b0;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic        frame_tick;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NDIG     (NDIG),
    .SLOT_CYC (SLOT),
    .BLANK_CYC(BLANK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digits_in (digits_in),
    .load      (load),
    .lzb_en    (lzb_en),
    .bcd_out   (bcd_out),
    .an        (an),
    .frame_tick(frame_tick)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          k     = 0;      // cycle number since reset release
  logic [15:0] latest = '0;    // most recent loaded value
  logic [15:0] mdisp  = '0;    // value shown in the current frame

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  // Apply inputs for one edge, then compare cycle k's outputs with the model.
  task automatic cycle(input logic ld, input logic [15:0] val, input logic lz);
    int          i;
    int          pos;
    logic [15:0] hi;
    logic [3:0]  e_an;
    logic [3:0]  e_bcd;
    load      = ld;
    digits_in = val;
    lzb_en    = lz;
    @(posedge clk);
    if (ld) latest = val;
    if (k > 0 && (k % FRAME) == 0) mdisp = latest;
    i     = (k / SLOT) % NDIG;
    pos   = k % SLOT;
    hi    = mdisp >> (4 * i);
    e_an  = 4'hF;
    e_bcd = 4'hF;
    if (pos >= BLANK && !(lz && i > 0 && hi == 16'h0)) begin
      e_an  = ~(4'b0001 << i);
      e_bcd = hi[3:0];
    end
    #1;
    check_val("an", 16'(an), 16'(e_an));
    check_val("bcd", 16'(bcd_out), 16'(e_bcd));
    check_val("tick", 16'(frame_tick), 16'((k % FRAME) == 0));
    k++;
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    v = '0;
    for (int n = 0; n < 4; n++) begin
      if ($urandom_range(0, 1) == 1) v = v | (16'($urandom_range(1, 15)) << (4 * n));
    end
    return v;
  endfunction

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_an", 16'(an), 16'hF);
    check_val("rst_bcd", 16'(bcd_out), 16'hF);
    check_val("rst_tick", 16'(frame_tick), 16'h0);
    @(negedge clk);
    rst = 1'b0;

    // Frame 0 shows zeros; 4321 loaded early appears in frame 1.
    for (int c = 0; c < FRAME; c++) cycle(c == 5, 16'h4321, 1'b0);
    // Load during the digit-2 slot must not tear frame 1.
    for (int c = 0; c < FRAME; c++) cycle(c == 19, 16'h9876, 1'b0);
    for (int c = 0; c < FRAME; c++) cycle(1'b0, 16'h0, 1'b0);
    // Load in the last cycle of digit 3 bypasses straight into frame 3.
    for (int c = 0; c < FRAME; c++) cycle(c == 0 || c == 10, (c == 0) ? 16'h5555 : 16'h0070, 1'b0);
    for (int c = 0; c < FRAME; c++) cycle(c == 5, 16'h0000, 1'b1);
    for (int c = 0; c < FRAME; c++) cycle(1'b0, 16'h0, 1'b1);
    for (int c = 0; c < FRAME; c++) cycle(1'b0, 16'h0, 1'b0);

    for (int c = 0; c < 8 * FRAME; c++) begin
      cycle($urandom_range(0, 11) == 0, rand_digits(), 1'(($urandom_range(0, 3) != 0)));
    end

    // Asynchronous reset in the ON phase of digit 2.
    while ((k % FRAME) != 21) cycle(1'b0, 16'h0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_an", 16'(an), 16'hF);
    check_val("arst_bcd", 16'(bcd_out), 16'hF);
    check_val("arst_tick", 16'(frame_tick), 16'h0);
    @(negedge clk);
    rst    = 1'b0;
    k      = 0;
    latest = '0;
    mdisp  = '0;
    for (int c = 0; c < 2 * FRAME; c++) cycle(1'b0, 16'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. It holds a frame of packed BCD digits and selects one digit per time slot. For each slot it drives that digit's 4-bit code to the shared BCD-to-7-segment decoder and asserts the matching anode. The block sits between the register or counter logic that produces the number and the single shared decoder instance, and owns refresh timing, anti-ghosting blanking, tear-free frame update and leading-zero suppression.

## Interface
- NDIG, 4: number of digits, at least 1.
- SLOT_CYC, 50000: clocks per digit slot, at least BLANK_CYC+2.
- BLANK_CYC, 500: clocks at the start of each slot with all anodes off (anti-ghosting). 0 disables blanking.
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- digits_in  input  4*NDIG  packed BCD. Digit i is in [4i+3:4i]; digit 0 is least significant and rightmost.
- load  input  1  one-cycle strobe that captures digits_in into the pending buffer.
- lzb_en  input  1  enables leading-zero blanking.
- bcd_out  output  4  code to the shared decoder. 4'hF means blank; the decoder's default arm turns all segments off.
- an  output  NDIG  anode enables, active-low, one-hot-low or all-high.
- frame_tick  output  1  one-cycle pulse in the first cycle of the digit-0 slot.

## Operation
- Registers:
  - pend: pending frame, NDIG×4.
  - disp: displayed frame.
  - idx: digit index, width clog2(NDIG) with a minimum of 1.
  - cnt: slot counter, width clog2(SLOT_CYC).
  - state: BLANK or ON.
- State machine:
  - BLANK: an all 1, bcd_out=4'hF. When cnt==BLANK_CYC-1, go to ON.
  - ON: an[idx]=0 unless the digit is suppressed; bcd_out=disp[idx].
  - Slot end (cnt==SLOT_CYC-1): cnt←0, idx←idx+1, wrapping NDIG-1→0. Next state is BLANK, or ON if BLANK_CYC==0.
- Frame update:
  - load=1 sets pend←digits_in, and a new load overwrites an unconsumed one.
  - At the slot-end edge of digit NDIG-1, disp←pend.
  - If load is asserted in that same cycle, disp←digits_in directly (bypass).
  - disp never changes mid-frame, so there is no tearing.
- Leading-zero blanking (lzb_en=1): digit i>0 is suppressed when disp[i] and every higher digit equal 0. A suppressed digit gets an all 1 and bcd_out=4'hF. Digit 0 is never suppressed.
- lzb_en is sampled per cycle with no latching.
- Codes 10–14 pass through unchanged; the decoder blanks them.

## Timing
- Reset values: an all 1, bcd_out=4'hF, frame_tick=0, idx=0, cnt=0, state=BLANK (ON if BLANK_CYC==0), pend=0, disp=0.
- Outputs are registered and update on the same edge as state/idx.
- Slot length is exactly SLOT_CYC clocks: BLANK_CYC blank, then SLOT_CYC-BLANK_CYC active.
- Frame length is NDIG×SLOT_CYC.
- frame_tick is high in cycle 0 of every digit-0 slot, including the first slot after reset release.
- A load in any cycle becomes visible at the next digit-0 slot, which is at most one frame later.
- Only one anode is ever low. There is no cycle with two anodes low, including across slot boundaries when BLANK_CYC=0.
- Reset asserted mid-slot forces all outputs to reset values immediately (asynchronously). Scanning restarts from digit 0 on release.

## Structure
- Shared package/header constants:
  - BCD_BLANK=4'hF.
  - ANODE_OFF (all ones).
  - State encoding ST_BLANK/ST_ON.
  - The digit-field width 4.
- Sub-module seg7_lzb_mask: combinational, NDIG×4 in, NDIG suppress mask out, computed as a high-to-low zero chain.
- The decoder is not instantiated inside this block; the top level connects bcd_out to it.

## Test plan
Parameters: NDIG=4, SLOT_CYC=8, BLANK_CYC=2.
- **Reset:** hold rst 3 cycles → an=4'b1111, bcd_out=4'hF. After release, frame_tick=1 in the first cycle. an=4'b1110 and bcd_out=0 from cycles 2–7, then the digit-1 slot starts at cycle 8.
- **Scan order:** load 16'h4321 → in the next frame, an cycles 1110/1101/1011/0111 with bcd_out 1,2,3,4. Each active window is 6 cycles, separated by 2 cycles of an=1111.
- **Tear-free update:** load 16'h9876 during the digit-2 slot → digits 2 and 3 still show 3 and 4. 9876 appears from the next frame_tick.
- **Bypass at boundary:** load 16'h5555 exactly in the last cycle of the digit-3 slot → the following frame shows 5,5,5,5.
- **Leading-zero blanking:**
  - lzb_en=1 with 16'h0070 → digits 3 and 2 have an=1111 with bcd_out=F; digit 1 shows 7; digit 0 shows 0.
  - 16'h0000 → only digit 0 lights, showing 0.
  - lzb_en=0 → all four digits light.
- **Mid-operation reset:** assert rst during the ON phase of digit 2 → an=1111 in the same cycle with no clock edge needed. After release, the scan restarts at digit 0 and disp=0.
